// File: rtl/board_attack_pipe.sv
// board_attack_pipe
//
// Streams tagged chess boards through CHANNELS parallel attack engines and
// returns the results in acceptance order through a small result FIFO.
//
// Board encoding (BOARD_WIDTH = 256): square s = row<<3|col occupies
// bits [4*s+3:4*s]. Row 0 is white's back rank and col 0 is the a-file.
// Nibble bit 3 is the colour (0 white, 1 black). Bits [2:0] are the piece:
// 0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king.
//
// Ports (top, board_attack_pipe):
//   clk, reset            clock, synchronous active-high reset
//   board_in/tag_in       board and opaque tag offered upstream
//   board_in_valid/ready  input handshake
//   out_valid/out_ready   output handshake (first-word fall-through)
//   out_tag               tag of the head result
//   white/black_is_attacking  64-bit attack maps
//   white/black_in_check  king-attacked flags
//   white/black_attack_count  popcounts of the maps
//   busy                  any channel active or any result buffered
//
// Engine latency E = 1: attacking_valid follows board_valid by one cycle.

// Combinational attack test of one target square by one side.
module is_attacking #(
  parameter int   SQUARE = 0,
  parameter logic SIDE   = 1'b0
) (
  input  logic [255:0] board,
  output logic         attacked,
  output logic         opponent_in_check
);
  localparam int ROW = SQUARE / 8;
  localparam int COL = SQUARE % 8;
  localparam logic [2:0] EMPTY  = 3'd0;
  localparam logic [2:0] PAWN   = 3'd1;
  localparam logic [2:0] KNIGHT = 3'd2;
  localparam logic [2:0] BISHOP = 3'd3;
  localparam logic [2:0] ROOK   = 3'd4;
  localparam logic [2:0] QUEEN  = 3'd5;
  localparam logic [2:0] KING   = 3'd6;
  // Directions 0..3 are orthogonal, 4..7 diagonal; also the king's neighbours.
  localparam int RAY_DR [8] = '{1, -1, 0, 0, 1, 1, -1, -1};
  localparam int RAY_DC [8] = '{0, 0, 1, -1, 1, -1, 1, -1};
  localparam int KN_DR  [8] = '{1, 2, 2, 1, -1, -2, -2, -1};
  localparam int KN_DC  [8] = '{2, 1, -1, -2, -2, -1, 1, 2};

  logic [3:0] sq [64];
  for (genvar g = 0; g < 64; g++) begin : g_unpack
    assign sq[g] = board[4*g +: 4];
  end

  function automatic logic on_board(input int r, input int c);
    return (r >= 0) && (r < 8) && (c >= 0) && (c < 8);
  endfunction

  function automatic logic [5:0] sq_idx(input int r, input int c);
    return 6'((r << 3) | c);
  endfunction

  int         r;
  int         c;
  logic       blocked;
  logic [3:0] p;

  always_comb begin
    attacked = 1'b0;
    blocked  = 1'b0;
    r        = 0;
    c        = 0;
    p        = '0;
    for (int d = 0; d < 8; d++) begin
      r = ROW + RAY_DR[d];
      c = COL + RAY_DC[d];
      if (on_board(r, c) && (sq[sq_idx(r, c)] == {SIDE, KING})) attacked = 1'b1;
      r = ROW + KN_DR[d];
      c = COL + KN_DC[d];
      if (on_board(r, c) && (sq[sq_idx(r, c)] == {SIDE, KNIGHT})) attacked = 1'b1;
      // Sliding pieces: only the first occupied square along the ray counts.
      blocked = 1'b0;
      for (int k = 1; k < 8; k++) begin
        r = ROW + k * RAY_DR[d];
        c = COL + k * RAY_DC[d];
        if (!blocked && on_board(r, c)) begin
          p = sq[sq_idx(r, c)];
          if (p[2:0] != EMPTY) begin
            blocked = 1'b1;
            if ((p[3] == SIDE) &&
                ((p[2:0] == QUEEN) || (p[2:0] == ((d < 4) ? ROOK : BISHOP))))
              attacked = 1'b1;
          end
        end
      end
    end
    // Pawns capture diagonally forward: white upward, black downward.
    for (int k = 0; k < 2; k++) begin
      r = SIDE ? ROW + 1 : ROW - 1;
      c = (k == 0) ? COL - 1 : COL + 1;
      if (on_board(r, c) && (sq[sq_idx(r, c)] == {SIDE, PAWN})) attacked = 1'b1;
    end
  end

  assign opponent_in_check = attacked && (board[4*SQUARE +: 4] == {~SIDE, KING});
endmodule

// One attack engine: 64 white and 64 black is_attacking instances, registered.
module attack_engine (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] board,
  input  logic         board_valid,
  output logic         attacking_valid,
  output logic [63:0]  white_map,
  output logic [63:0]  black_map,
  output logic [63:0]  white_opp_check,
  output logic [63:0]  black_opp_check
);
  logic [63:0] w_att, b_att, w_opp, b_opp;
  logic        vld_p1;
  logic [63:0] w_att_p1, b_att_p1, w_opp_p1, b_opp_p1;

  for (genvar g = 0; g < 64; g++) begin : g_sq
    is_attacking #(.SQUARE(g), .SIDE(1'b0)) u_white (
      .board             (board),
      .attacked          (w_att[g]),
      .opponent_in_check (w_opp[g])
    );
    is_attacking #(.SQUARE(g), .SIDE(1'b1)) u_black (
      .board             (board),
      .attacked          (b_att[g]),
      .opponent_in_check (b_opp[g])
    );
  end

  // ---- stage p1: registered attack maps ----
  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= board_valid;
  end

  always_ff @(posedge clk) begin
    w_att_p1 <= w_att;
    b_att_p1 <= b_att;
    w_opp_p1 <= w_opp;
    b_opp_p1 <= b_opp;
  end

  assign attacking_valid = vld_p1;
  assign white_map       = w_att_p1;
  assign black_map       = b_att_p1;
  assign white_opp_check = w_opp_p1;
  assign black_opp_check = b_opp_p1;
endmodule

module board_attack_pipe #(
  parameter  int CHANNELS    = 2,
  parameter  int FIFO_DEPTH  = 4,
  parameter  int TAG_WIDTH   = 4,
  localparam int BOARD_WIDTH = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BOARD_WIDTH-1:0] board_in,
  input  logic [TAG_WIDTH-1:0]   tag_in,
  input  logic                   board_in_valid,
  output logic                   board_in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TAG_WIDTH-1:0]   out_tag,
  output logic [63:0]            white_is_attacking,
  output logic [63:0]            black_is_attacking,
  output logic                   white_in_check,
  output logic                   black_in_check,
  output logic [6:0]             white_attack_count,
  output logic [6:0]             black_attack_count,
  output logic                   busy
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n = n + {6'd0, v[i]};
    return n;
  endfunction

  function automatic logic [CW-1:0] next_ch(input logic [CW-1:0] ch);
    return (ch == CW'(CHANNELS - 1)) ? '0 : ch + 1'b1;
  endfunction

  logic [1:0]           ch_state [CHANNELS];
  logic [TAG_WIDTH-1:0] ch_tag   [CHANNELS];
  logic [63:0]          ch_wmap  [CHANNELS];
  logic [63:0]          ch_bmap  [CHANNELS];
  logic                 ch_wchk  [CHANNELS];
  logic                 ch_bchk  [CHANNELS];

  logic [CW-1:0] dp, rp;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_count;
  logic [2:0]    in_flight;
  logic          accept, retire, pop;

  logic [TAG_WIDTH-1:0] fifo_tag  [FIFO_DEPTH];
  logic [63:0]          fifo_wmap [FIFO_DEPTH];
  logic [63:0]          fifo_bmap [FIFO_DEPTH];
  logic                 fifo_wchk [FIFO_DEPTH];
  logic                 fifo_bchk [FIFO_DEPTH];
  logic [6:0]           fifo_wcnt [FIFO_DEPTH];
  logic [6:0]           fifo_bcnt [FIFO_DEPTH];

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (ch_state[i] != ST_IDLE) in_flight = in_flight + 3'd1;
  end

  // A board is taken only if a FIFO slot is reserved for every result in flight.
  assign board_in_ready = !reset && (ch_state[dp] == ST_IDLE) &&
                          ((int'(fifo_count) + int'(in_flight)) < FIFO_DEPTH);
  assign accept    = board_in_valid && board_in_ready;
  assign retire    = (ch_state[rp] == ST_DONE);
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign busy      = (in_flight != '0) || out_valid;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic                   dispatch, retire_me;
    logic [1:0]             state;
    logic                   bv_p0;
    logic [BOARD_WIDTH-1:0] board_p0;
    logic [TAG_WIDTH-1:0]   tag_p0;
    logic                   eng_vld_p1;
    logic [63:0]            eng_wmap_p1, eng_bmap_p1, eng_wopp_p1, eng_bopp_p1;
    logic [63:0]            wmap_p2, bmap_p2;
    logic                   wchk_p2, bchk_p2;

    assign dispatch  = accept && (dp == CW'(i));
    assign retire_me = retire && (rp == CW'(i));

    always_ff @(posedge clk) begin
      if (reset) begin
        state <= ST_IDLE;
        bv_p0 <= 1'b0;
      end else begin
        bv_p0 <= dispatch;
        case (state)
          ST_IDLE: if (dispatch)   state <= ST_RUN;
          ST_RUN:  if (eng_vld_p1) state <= ST_DONE;
          ST_DONE: if (retire_me)  state <= ST_IDLE;
          default:                 state <= ST_IDLE;
        endcase
      end
    end

    // ---- stage p0: latched board and tag ----
    always_ff @(posedge clk) begin
      if (dispatch) begin
        board_p0 <= board_in;
        tag_p0   <= tag_in;
      end
    end

    attack_engine u_engine (
      .clk             (clk),
      .reset           (reset),
      .board           (board_p0),
      .board_valid     (bv_p0),
      .attacking_valid (eng_vld_p1),
      .white_map       (eng_wmap_p1),
      .black_map       (eng_bmap_p1),
      .white_opp_check (eng_wopp_p1),
      .black_opp_check (eng_bopp_p1)
    );

    // ---- stage p2: captured results, held until retired ----
    // White's opponent_in_check bits mark an attacked black king, and vice versa.
    always_ff @(posedge clk) begin
      if ((state == ST_RUN) && eng_vld_p1) begin
        wmap_p2 <= eng_wmap_p1;
        bmap_p2 <= eng_bmap_p1;
        bchk_p2 <= |eng_wopp_p1;
        wchk_p2 <= |eng_bopp_p1;
      end
    end

    assign ch_state[i] = state;
    assign ch_tag[i]   = tag_p0;
    assign ch_wmap[i]  = wmap_p2;
    assign ch_bmap[i]  = bmap_p2;
    assign ch_wchk[i]  = wchk_p2;
    assign ch_bchk[i]  = bchk_p2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dp         <= '0;
      rp         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (accept) dp <= next_ch(dp);
      if (retire) begin
        rp     <= next_ch(rp);
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({retire, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---- stage p3: result FIFO write ----
  always_ff @(posedge clk) begin
    if (retire) begin
      fifo_tag[wr_ptr]  <= ch_tag[rp];
      fifo_wmap[wr_ptr] <= ch_wmap[rp];
      fifo_bmap[wr_ptr] <= ch_bmap[rp];
      fifo_wchk[wr_ptr] <= ch_wchk[rp];
      fifo_bchk[wr_ptr] <= ch_bchk[rp];
      fifo_wcnt[wr_ptr] <= popcount64(ch_wmap[rp]);
      fifo_bcnt[wr_ptr] <= popcount64(ch_bmap[rp]);
    end
  end

  // FIFO storage is not reset, so the head is masked to zero while empty.
  assign out_tag            = out_valid ? fifo_tag[rd_ptr]  : '0;
  assign white_is_attacking = out_valid ? fifo_wmap[rd_ptr] : '0;
  assign black_is_attacking = out_valid ? fifo_bmap[rd_ptr] : '0;
  assign white_in_check     = out_valid ? fifo_wchk[rd_ptr] : 1'b0;
  assign black_in_check     = out_valid ? fifo_bchk[rd_ptr] : 1'b0;
  assign white_attack_count = out_valid ? fifo_wcnt[rd_ptr] : '0;
  assign black_attack_count = out_valid ? fifo_bcnt[rd_ptr] : '0;
endmodule

// File: tb/tb_board_attack_pipe.sv
// Directed testbench for board_attack_pipe (CHANNELS=2, FIFO_DEPTH=4, TAG_WIDTH=4).
module tb_board_attack_pipe;
  localparam int E = 1;
  localparam logic [3:0] WK = 4'h6;
  localparam logic [3:0] BK = 4'hE;
  localparam logic [3:0] WR = 4'h4;
  localparam logic [3:0] BP = 4'h9;
  localparam logic [3:0] BB = 4'hB;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] board_in;
  logic [3:0]   tag_in;
  logic         board_in_valid;
  logic         board_in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_tag;
  logic [63:0]  white_is_attacking;
  logic [63:0]  black_is_attacking;
  logic         white_in_check;
  logic         black_in_check;
  logic [6:0]   white_attack_count;
  logic [6:0]   black_attack_count;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  board_attack_pipe #(.CHANNELS(2), .FIFO_DEPTH(4), .TAG_WIDTH(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .board_in           (board_in),
    .tag_in             (tag_in),
    .board_in_valid     (board_in_valid),
    .board_in_ready     (board_in_ready),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_tag            (out_tag),
    .white_is_attacking (white_is_attacking),
    .black_is_attacking (black_is_attacking),
    .white_in_check     (white_in_check),
    .black_in_check     (black_in_check),
    .white_attack_count (white_attack_count),
    .black_attack_count (black_attack_count),
    .busy               (busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] place(input logic [255:0] b, input int s, input logic [3:0] pc);
    logic [255:0] r;
    r = b;
    r[s*4 +: 4] = pc;
    return r;
  endfunction

  // Offer one board; returns just after the accepting edge.
  task automatic send(input logic [255:0] b, input logic [3:0] t);
    int waited;
    waited = 0;
    @(negedge clk);
    board_in = b;
    tag_in = t;
    board_in_valid = 1'b1;
    while (!board_in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check("send_timeout", 64'(waited), 64'd0);
    @(posedge clk);
    #1 board_in_valid = 1'b0;
  endtask

  // Pop one result and compare its tag.
  task automatic recv(input logic [3:0] exp_tag);
    int waited;
    waited = 0;
    @(negedge clk);
    out_ready = 1'b1;
    while (!out_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("recv_valid", 64'(out_valid), 64'd1);
    check("recv_tag", 64'(out_tag), 64'(exp_tag));
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  // One board end to end with full result and latency comparison.
  task automatic run_one(input string nm, input logic [255:0] b, input logic [3:0] t,
                         input logic [63:0] wm, input logic [63:0] bm,
                         input logic wc, input logic bc,
                         input logic [6:0] wn, input logic [6:0] bn);
    int lat;
    out_ready = 1'b1;
    send(b, t);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_latency"}, 64'(lat), 64'(3 + E));
    check({nm, "_tag"}, 64'(out_tag), 64'(t));
    check({nm, "_wmap"}, white_is_attacking, wm);
    check({nm, "_bmap"}, black_is_attacking, bm);
    check({nm, "_wchk"}, 64'(white_in_check), 64'(wc));
    check({nm, "_bchk"}, 64'(black_in_check), 64'(bc));
    check({nm, "_wcnt"}, 64'(white_attack_count), 64'(wn));
    check({nm, "_bcnt"}, 64'(black_attack_count), 64'(bn));
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  logic [255:0] b_kings, b_rook, b_bish, b_pawn;
  int accepted;

  initial begin
    reset = 1'b1;
    board_in = '0;
    tag_in = '0;
    board_in_valid = 1'b0;
    out_ready = 1'b0;
    b_kings = place(place('0, 4, WK), 60, BK);
    b_rook  = place(b_kings, 12, WR);
    b_bish  = place(b_kings, 25, BB);
    b_pawn  = place(b_kings, 11, BP);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_in_reset", 64'(board_in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ready_after", 64'(board_in_ready), 64'd1);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_wmap", white_is_attacking, 64'd0);
    check("rst_bcnt", 64'(black_attack_count), 64'd0);

    // Single boards
    run_one("kings", b_kings, 4'd5, 64'h0000_0000_0000_3828, 64'h2838_0000_0000_0000,
            1'b0, 1'b0, 7'd5, 7'd5);
    run_one("rook", b_rook, 4'd6, 64'h1010_1010_1010_FF38, 64'h2838_0000_0000_0000,
            1'b0, 1'b1, 7'd17, 7'd5);
    run_one("bishop", b_bish, 4'd7, 64'h0000_0000_0000_3828, 64'h2838_0805_0005_0810,
            1'b1, 1'b0, 7'd5, 7'd12);
    run_one("pawn", b_pawn, 4'd8, 64'h0000_0000_0000_3828, 64'h2838_0000_0000_0014,
            1'b1, 1'b0, 7'd5, 7'd7);
    @(negedge clk);
    check("single_busy_idle", 64'(busy), 64'd0);

    // Back-to-back stream of 8 boards, results in tag order
    fork
      begin
        for (int i = 0; i < 8; i++) send(b_kings, 4'(i));
      end
      begin
        for (int j = 0; j < 8; j++) recv(4'(j));
      end
    join
    @(negedge clk);
    check("stream_busy_low", 64'(busy), 64'd0);
    check("stream_empty", 64'(out_valid), 64'd0);

    // Back-pressure: out_ready low, boards offered continuously
    accepted = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      board_in = b_kings;
      tag_in = 4'(accepted);
      board_in_valid = 1'b1;
      if (board_in_ready) accepted++;
    end
    @(negedge clk);
    board_in_valid = 1'b0;
    check("bp_accepted", 64'(accepted), 64'd4);
    check("bp_ready_low", 64'(board_in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    for (int k = 0; k < 4; k++) recv(4'(k));
    @(negedge clk);
    check("bp_ready_resumes", 64'(board_in_ready), 64'd1);

    // Full FIFO drained while new boards retire into it
    for (int k = 8; k < 12; k++) send(b_kings, 4'(k));
    repeat (8) @(negedge clk);
    check("full_ready_low", 64'(board_in_ready), 64'd0);
    fork
      begin
        for (int i = 12; i < 16; i++) send(b_kings, 4'(i));
      end
      begin
        for (int j = 8; j < 16; j++) recv(4'(j));
      end
    join
    @(negedge clk);
    check("full_drained", 64'(busy), 64'd0);

    // Reset with one buffered result and two boards in flight
    send(b_kings, 4'd1);
    repeat (6) @(negedge clk);
    send(b_kings, 4'd2);
    send(b_kings, 4'd3);
    @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(board_in_ready), 64'd1);
    send(b_kings, 4'd9);
    recv(4'd9);
    @(negedge clk);
    check("post_rst_empty", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
